alarm_ring_controller: RTL

- Sits directly downstream of the top-level clock/alarm comparison: consumes the displayed clock time, the stored alarm time and button pulses, and produces the ring enable for the Melody block plus the alarm LED.
- Adds snooze with minute-accurate re-trigger, dismiss, auto-timeout after a fixed ring duration, and single-shot triggering per matching minute.

---
 rtl/alarm_ring_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alarm_ring_controller.sv
// alarm_ring_controller
//
// Sits behind the clock/alarm time comparison. It rings once per matching
// minute, lets the user snooze a limited number of times (re-triggering at an
// exact minute), dismiss, or let the ring time out after a fixed number of
// seconds.
//
// Ports:
//   clk          system clock
//   RESET        asynchronous, active-low reset
//   en_check     high while the clock is in normal display mode
//   hours12_24   1 = 12 h format (hours 0..11), 0 = 24 h format (hours 0..23)
//   time_now     {hour, minute} of the running clock, binary
//   alarm_time   {hour, minute} of the stored alarm, binary
//   sec_tick     one-cycle pulse per second
//   snooze       one-cycle pulse from the snooze button
//   dismiss      one-cycle pulse from the dismiss button
//   ring         melody enable
//   led          alarm LED (blinks while ringing, steady while snoozing)
//   snoozing     high while waiting for the snooze minute
//   snooze_left  snoozes still available for the current alarm event
module alarm_ring_controller #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        en_check,
    input  logic        hours12_24,
    input  logic [15:0] time_now,
    input  logic [15:0] alarm_time,
    input  logic        sec_tick,
    input  logic        snooze,
    input  logic        dismiss,
    output logic        ring,
    output logic        led,
    output logic        snoozing,
    output logic [1:0]  snooze_left
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZE  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [1:0]         state_q, state_d;
    logic [7:0]         sec_cnt_q, sec_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               led_q, led_d;
    logic [1:0]         snooze_left_q, snooze_left_d;
    logic [15:0]        snooze_target_q, snooze_target_d;
    logic [15:0]        trig_time_q, trig_time_d;

    logic [7:0]         tgt_min, tgt_hour;
    logic [15:0]        snooze_target_calc;

    // Time SNOOZE_MIN minutes from now, with minute carry into the hour and
    // the hour wrapping at 12 or 24 depending on the display format.
    always_comb begin
        tgt_min  = time_now[7:0] + 8'(SNOOZE_MIN);
        tgt_hour = time_now[15:8];
        if (tgt_min >= 8'd60) begin
            tgt_min  = tgt_min - 8'd60;
            tgt_hour = tgt_hour + 8'd1;
        end
        if (tgt_hour >= (hours12_24 ? 8'd12 : 8'd24)) begin
            tgt_hour = 8'd0;
        end
        snooze_target_calc = {tgt_hour, tgt_min};
    end

    // Next-state logic. Every entry into RINGING restarts the ring-second
    // counter and the blink phase, so a re-trigger after snooze gets a full
    // ring period starting with the LED lit.
    always_comb begin
        state_d         = state_q;
        sec_cnt_d       = sec_cnt_q;
        blink_cnt_d     = blink_cnt_q;
        led_d           = led_q;
        snooze_left_d   = snooze_left_q;
        snooze_target_d = snooze_target_q;
        trig_time_d     = trig_time_q;

        case (state_q)
            ST_IDLE: begin
                if (en_check && (time_now == alarm_time)) begin
                    state_d       = ST_RINGING;
                    trig_time_d   = time_now;
                    sec_cnt_d     = 8'd0;
                    snooze_left_d = 2'(MAX_SNOOZE);
                    led_d         = 1'b1;
                    blink_cnt_d   = '0;
                end
            end

            ST_RINGING: begin
                if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                    blink_cnt_d = '0;
                    led_d       = ~led_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end

                // A snooze with none left is simply ignored, so the ring
                // keeps timing out normally on that cycle.
                if (!en_check) begin
                    state_d = ST_DONE;
                end else if (dismiss) begin
                    state_d = ST_DONE;
                end else if (snooze && (snooze_left_q != 2'd0)) begin
                    state_d         = ST_SNOOZE;
                    snooze_target_d = snooze_target_calc;
                    snooze_left_d   = snooze_left_q - 2'd1;
                end else if (sec_tick) begin
                    if (sec_cnt_q == 8'(RING_SEC - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 8'd1;
                    end
                end
            end

            ST_SNOOZE: begin
                if (dismiss) begin
                    state_d = ST_DONE;
                end else if (en_check && (time_now == snooze_target_q)) begin
                    state_d     = ST_RINGING;
                    sec_cnt_d   = 8'd0;
                    trig_time_d = time_now;
                    led_d       = 1'b1;
                    blink_cnt_d = '0;
                end
            end

            ST_DONE: begin
                // Stay here until the minute that triggered us has passed,
                // otherwise IDLE would immediately match again.
                if (time_now != trig_time_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q         <= ST_IDLE;
            sec_cnt_q       <= 8'd0;
            blink_cnt_q     <= '0;
            led_q           <= 1'b0;
            snooze_left_q   <= 2'(MAX_SNOOZE);
            snooze_target_q <= 16'd0;
            trig_time_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            sec_cnt_q       <= sec_cnt_d;
            blink_cnt_q     <= blink_cnt_d;
            led_q           <= led_d;
            snooze_left_q   <= snooze_left_d;
            snooze_target_q <= snooze_target_d;
            trig_time_q     <= trig_time_d;
        end
    end

    // Outputs decode registered state only; reset clears them without a clock.
    assign ring        = (state_q == ST_RINGING);
    assign snoozing    = (state_q == ST_SNOOZE);
    assign led         = (state_q == ST_SNOOZE) || ((state_q == ST_RINGING) && led_q);
    assign snooze_left = snooze_left_q;

endmodule
